// File: rtl/stimulus_recorder.sv
// rtl/stimulus_recorder.sv - records synchronized switch/button stimulus per step tick and replays it via a registered read port
//
// Purpose: captures live {SW[2:0], KEY[1]} stimulus, one word per tick, into a
// small register memory so a recorded session can replace the fixed automation
// pattern. The read port mimics the automation ROM: address in, q out one clock later.
//
// Ports:
//   clock      in   single clock for all logic
//   reset      in   asynchronous, active-high
//   tick       in   one-cycle step-enable pulse
//   rec_start  in   one-cycle pulse: clear and begin recording
//   rec_stop   in   one-cycle pulse: end recording early
//   din        in   live stimulus, asynchronous to clock
//   rd_addr    in   playback read address
//   q          out  registered read data
//   count      out  number of valid recorded words, 0..DEPTH
//   recording  out  high while recording
//   full       out  high once all DEPTH steps are recorded
module stimulus_recorder #(
  parameter int                 DEPTH     = 6,
  parameter int                 WIDTH     = 4,
  parameter int                 ADDR_W    = 3,
  parameter logic [WIDTH-1:0]   IDLE_WORD = 4'b0001
) (
  input  logic              clock,
  input  logic              reset,
  input  logic              tick,
  input  logic              rec_start,
  input  logic              rec_stop,
  input  logic [WIDTH-1:0]  din,
  input  logic [ADDR_W-1:0] rd_addr,
  output logic [WIDTH-1:0]  q,
  output logic [ADDR_W:0]   count,
  output logic              recording,
  output logic              full
);

  localparam int CNT_W = ADDR_W + 1;

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_REC  = 2'd1;
  localparam logic [1:0] S_FULL = 2'd2;

  logic [1:0]        state_q, state_d;
  logic [ADDR_W-1:0] wr_ptr_q, wr_ptr_d;
  logic [CNT_W-1:0]  count_q, count_d;
  logic [WIDTH-1:0]  sync1_q, din_s;
  logic [WIDTH-1:0]  q_q;
  logic [WIDTH-1:0]  rd_word;
  logic              wr_en;
  logic [WIDTH-1:0]  mem_q [DEPTH];

  // Two-flop synchronizer; reset value matches the idle stimulus so a
  // freshly reset board never records a spurious button press.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      sync1_q <= IDLE_WORD;
      din_s   <= IDLE_WORD;
    end else begin
      sync1_q <= din;
      din_s   <= sync1_q;
    end
  end

  // rec_start has priority over everything; in REC it also suppresses the
  // tick so a restart never leaves a stale word at address 0.
  always_comb begin
    state_d  = state_q;
    wr_ptr_d = wr_ptr_q;
    count_d  = count_q;
    wr_en    = 1'b0;
    case (state_q)
      S_IDLE, S_FULL: begin
        if (rec_start) begin
          state_d  = S_REC;
          wr_ptr_d = '0;
          count_d  = '0;
        end
      end
      S_REC: begin
        if (rec_start) begin
          wr_ptr_d = '0;
          count_d  = '0;
        end else begin
          if (tick) begin
            wr_en    = 1'b1;
            wr_ptr_d = wr_ptr_q + ADDR_W'(1);
            count_d  = count_q + CNT_W'(1);
            if (count_q == CNT_W'(DEPTH - 1)) begin
              state_d = S_FULL;
            end
          end
          // A stop arriving with the tick still keeps the word just written.
          if (rec_stop) begin
            state_d = S_IDLE;
          end
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state_q  <= S_IDLE;
      wr_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      state_q  <= state_d;
      wr_ptr_q <= wr_ptr_d;
      count_q  <= count_d;
    end
  end

  // Memory is intentionally not reset; count_q masks stale contents.
  always_ff @(posedge clock) begin
    if (wr_en) begin
      for (int i = 0; i < DEPTH; i++) begin
        if (wr_ptr_q == ADDR_W'(i)) begin
          mem_q[i] <= din_s;
        end
      end
    end
  end

  // Read uses the pre-edge memory and count, so a same-cycle write to the
  // addressed slot returns the old contents. Addresses >= DEPTH fall through.
  always_comb begin
    rd_word = IDLE_WORD;
    for (int i = 0; i < DEPTH; i++) begin
      if ((rd_addr == ADDR_W'(i)) && (CNT_W'(i) < count_q)) begin
        rd_word = mem_q[i];
      end
    end
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      q_q <= IDLE_WORD;
    end else begin
      q_q <= rd_word;
    end
  end

  assign q         = q_q;
  assign count     = count_q;
  assign recording = (state_q == S_REC);
  assign full      = (state_q == S_FULL);

endmodule

// File: tb/tb_stimulus_recorder.sv
// tb/tb_stimulus_recorder.sv - scoreboard bench for stimulus_recorder
module tb_stimulus_recorder;

  logic       clock = 1'b0;
  logic       reset = 1'b1;
  logic       tick = 1'b0;
  logic       rec_start = 1'b0;
  logic       rec_stop = 1'b0;
  logic [3:0] din = 4'b0001;
  logic [2:0] rd_addr = 3'd0;
  logic [3:0] q;
  logic [3:0] count;
  logic       recording;
  logic       full;

  stimulus_recorder dut (
    .clock     (clock),
    .reset     (reset),
    .tick      (tick),
    .rec_start (rec_start),
    .rec_stop  (rec_stop),
    .din       (din),
    .rd_addr   (rd_addr),
    .q         (q),
    .count     (count),
    .recording (recording),
    .full      (full)
  );

  always #5 clock = ~clock;

  typedef struct {
    string      name;
    logic [3:0] eq;
    logic [3:0] ec;
    logic       er;
    logic       ef;
  } exp_t;

  exp_t sb[$];
  exp_t mon_e;
  exp_t stim_e;
  logic req = 1'b0;
  logic req_seen = 1'b0;
  int   tests = 0;
  int   fails = 0;

  // Monitor: a request issued in a cycle is judged after the following edge.
  always @(posedge clock) req_seen <= req;

  always @(negedge clock) begin
    if (req_seen) begin
      tests++;
      if (sb.size() == 0) begin
        fails++;
        $display("FAIL scoreboard_underflow: response with no expected entry");
      end else begin
        mon_e = sb.pop_front();
        if (q !== mon_e.eq || count !== mon_e.ec || recording !== mon_e.er || full !== mon_e.ef) begin
          fails++;
          $display("FAIL %s: got q=%b count=%0d rec=%b full=%b, expected q=%b count=%0d rec=%b full=%b",
                   mon_e.name, q, count, recording, full, mon_e.eq, mon_e.ec, mon_e.er, mon_e.ef);
        end
      end
    end
  end

  task automatic cyc(input logic t, input logic s, input logic p, input logic chk,
                     input logic [2:0] a, input logic [3:0] eq, input logic [3:0] ec,
                     input logic er, input logic ef, input string nm);
    tick = t; rec_start = s; rec_stop = p; rd_addr = a; req = chk;
    if (chk) begin
      stim_e.name = nm; stim_e.eq = eq; stim_e.ec = ec; stim_e.er = er; stim_e.ef = ef;
      sb.push_back(stim_e);
    end
    @(negedge clock);
    tick = 1'b0; rec_start = 1'b0; rec_stop = 1'b0; req = 1'b0;
  endtask

  task automatic idle(input int n);
    repeat (n) cyc(0, 0, 0, 0, 3'd0, 4'd0, 4'd0, 0, 0, "");
  endtask

  task automatic chk(input logic [2:0] a, input logic [3:0] eq, input logic [3:0] ec,
                     input logic er, input logic ef, input string nm);
    cyc(0, 0, 0, 1, a, eq, ec, er, ef, nm);
  endtask

  // Hold din long enough to cross the synchronizer, then tick once.
  task automatic rec_word(input logic [3:0] w, input logic [3:0] ec, input logic er,
                          input logic ef, input string nm);
    din = w;
    idle(3);
    cyc(1, 0, 0, 1, 3'd7, 4'b0001, ec, er, ef, nm);
  endtask

  logic [3:0] words [6] = '{4'b0011, 4'b0101, 4'b1001, 4'b1110, 4'b0001, 4'b0111};
  logic [3:0] part  [4] = '{4'b0110, 4'b1010, 4'b1101, 4'b0001};

  initial begin
    repeat (2) @(negedge clock);
    reset = 1'b0;

    for (int a = 0; a < 8; a++) chk(3'(a), 4'b0001, 4'd0, 0, 0, "reset_sweep");

    // Full six-step recording and readback.
    cyc(0, 1, 0, 1, 3'd7, 4'b0001, 4'd0, 1, 0, "start");
    for (int k = 0; k < 6; k++) rec_word(words[k], 4'(k + 1), k < 5, k == 5, "rec_fill");
    for (int a = 0; a < 8; a++) chk(3'(a), (a < 6) ? words[a] : 4'b0001, 4'd6, 0, 1, "full_read");

    // Early stop coincident with the third tick.
    cyc(0, 1, 0, 1, 3'd7, 4'b0001, 4'd0, 1, 0, "restart");
    rec_word(part[0], 4'd1, 1, 0, "part_tick");
    rec_word(part[1], 4'd2, 1, 0, "part_tick");
    din = part[2];
    idle(3);
    cyc(1, 0, 1, 1, 3'd7, 4'b0001, 4'd3, 0, 0, "tick_with_stop");
    repeat (4) cyc(1, 0, 0, 1, 3'd7, 4'b0001, 4'd3, 0, 0, "idle_tick_ignored");
    for (int a = 0; a < 4; a++) chk(3'(a), part[a], 4'd3, 0, 0, "part_read");

    // From FULL: start+stop+tick together restarts without writing.
    din = 4'b1000;
    idle(3);
    cyc(0, 1, 0, 0, 3'd0, 4'd0, 4'd0, 0, 0, "");
    for (int k = 1; k <= 6; k++) cyc(1, 0, 0, 1, 3'd7, 4'b0001, 4'(k), k < 6, k == 6, "refill");
    cyc(1, 1, 1, 1, 3'd7, 4'b0001, 4'd0, 1, 0, "start_stop_tick");
    rec_word(4'b0100, 4'd1, 1, 0, "tick_after_restart");
    chk(3'd0, 4'b0100, 4'd1, 1, 0, "restart_read0");
    chk(3'd1, 4'b0001, 4'd1, 1, 0, "restart_read1");

    // Asynchronous reset during recording.
    cyc(0, 1, 0, 0, 3'd0, 4'd0, 4'd0, 0, 0, "");
    din = 4'b1011;
    idle(3);
    for (int k = 1; k <= 4; k++) cyc(1, 0, 0, 1, 3'd7, 4'b0001, 4'(k), 1, 0, "pre_reset_tick");
    #1 reset = 1'b1;
    #2 reset = 1'b0;
    chk(3'd0, 4'b0001, 4'd0, 0, 0, "after_reset_read");
    cyc(1, 0, 0, 1, 3'd7, 4'b0001, 4'd0, 0, 0, "tick_after_reset");
    chk(3'd0, 4'b0001, 4'd0, 0, 0, "after_reset_read2");

    // Read and write of the same address in one cycle.
    cyc(0, 1, 0, 1, 3'd7, 4'b0001, 4'd0, 1, 0, "rw_start");
    rec_word(4'b0010, 4'd1, 1, 0, "rw_tick");
    rec_word(4'b0100, 4'd2, 1, 0, "rw_tick");
    din = 4'b1111;
    idle(3);
    cyc(1, 0, 0, 1, 3'd2, 4'b0001, 4'd3, 1, 0, "rw_same_old");
    chk(3'd2, 4'b1111, 4'd3, 1, 0, "rw_same_new");

    idle(2);
    tests++;
    if (sb.size() != 0) begin
      fails++;
      $display("FAIL scoreboard_drain: %0d entries left, expected 0", sb.size());
    end
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/stimulus_recorder.md
# stimulus_recorder

Records live user stimulus, the 3-bit tail-light switch code plus the hazard/turn button, into a small internal memory, one word per step tick. It exposes a registered read port with the same address-in/q-out, one-cycle-latency behaviour as the automation ROM, so the top level can replay a recorded session instead of the fixed pattern. It sits between the board inputs (SW/KEY) and the automation mux, clocked by the slow state-machine clock.

## Interface
Parameters:
- DEPTH, 6, number of recordable steps (matches the playback counter wrap of 0..5)
- WIDTH, 4, word width; bit 0 = button, bits 3:1 = switch code
- ADDR_W, 3, address width; must satisfy 2**ADDR_W >= DEPTH
- IDLE_WORD, 4'b0001, word returned for unrecorded addresses (switches 0, button released; KEY is active-low)

Ports:
- clock  input  1  single clock for all logic
- reset  input  1  asynchronous, active-high
- tick  input  1  one-cycle step-enable pulse (playback step rate)
- rec_start  input  1  one-cycle pulse: clear and begin recording
- rec_stop  input  1  one-cycle pulse: end recording early
- din  input  WIDTH  live stimulus {SW[2:0], KEY[1]}, asynchronous to clock
- rd_addr  input  ADDR_W  playback read address
- q  output  WIDTH  registered read data
- count  output  ADDR_W+1  number of valid recorded words, 0..DEPTH
- recording  output  1  high in state REC
- full  output  1  high in state FULL

## Operation
- din passes through a 2-flop synchronizer (din_s); only din_s is ever written.
- Storage: DEPTH x WIDTH register array, write pointer wr_ptr (ADDR_W bits), count register.
- FSM states: IDLE, REC, FULL.
  - IDLE: rec_start -> REC with wr_ptr=0, count=0. Ticks are ignored.
  - REC: on tick, write din_s to mem[wr_ptr], increment wr_ptr and count. When the write brings count to DEPTH, go to FULL. rec_stop -> IDLE, count retained. rec_start -> restart: wr_ptr=0, count=0, stay in REC.
  - FULL: ticks ignored, no writes. rec_start -> REC with wr_ptr=0, count=0. rec_stop is ignored.
- Simultaneous events:
  - rec_start with rec_stop: rec_start wins.
  - tick with rec_stop in REC: the write happens, then the FSM goes to IDLE.
  - tick with rec_start in REC: restart wins and no write occurs.
- Read: every cycle, q <= (rd_addr < count) ? mem[rd_addr] : IDLE_WORD. Addresses >= DEPTH always return IDLE_WORD.
- Read/write same address in the same cycle: q returns the old contents.
- Outputs: recording = (state==REC); full = (state==FULL).

## Timing
- Reset, asynchronous: state=IDLE, wr_ptr=0, count=0, q=IDLE_WORD, synchronizer flops=IDLE_WORD. Memory contents are not cleared; count=0 masks them.
- Reset asserted mid-recording aborts immediately. Nothing recorded survives, because count=0.
- din-to-write: din must be stable for ≥2 clocks before the tick cycle. The word written is din_s at the tick edge.
- Write is visible on the read port at the edge after the write edge, so q updates one cycle later (q latency = 1 clock from rd_addr).
- count and full update on the same edge as the write. recording changes on the edge that samples rec_start/rec_stop.
- No combinational path from any input to any output.

## Test plan
- Reset with rd_addr swept 0..7: q=4'b0001 at every address, count=0, recording=0, full=0.
- rec_start, then 6 ticks with din=4'b0011, 0101, 1001, 1110, 0001, 0111 (held ≥2 clocks each): full=1 after the 6th tick, count=6; reading 0..5 returns those words one clock after each address; address 6 and 7 return 4'b0001.
- rec_start, 3 ticks, rec_stop in the same cycle as the 3rd tick: count=3, state IDLE, 3rd word stored; 4 further ticks leave count=3; address 3 returns 4'b0001.
- In FULL, rec_start with rec_stop plus tick in the same cycle: state REC, count=0, no write; next tick stores at address 0, count=1.
- Reset pulsed while in REC after 4 ticks: count=0 and q=4'b0001 on the next read; no write on the following tick until rec_start.
- Read address 2 in the same cycle as a tick writing address 2: q shows the previous contents (IDLE_WORD since count was 2), and the new word on the next cycle.
